// File: rtl/regfile_wb_scheduler_pkg.sv
// rtl/regfile_wb_scheduler_pkg.sv - shared register-file widths and types for the writeback scheduler
package regfile_ctrl_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]       xlen_t;

endpackage

// File: rtl/regfile_wb_scheduler_if.sv
// rtl/regfile_wb_scheduler_if.sv - issue, writeback and register-file write bundle
interface regfile_wb_scheduler_if #(
    parameter int NUM_REQ    = 2,
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
);
    import regfile_ctrl_pkg::*;

    logic                          issue_valid;
    logic [REG_ADDR_W-1:0]         issue_rd;
    logic [REG_ADDR_W-1:0]         issue_rs1;
    logic [REG_ADDR_W-1:0]         issue_rs2;
    logic                          issue_stall;

    logic [NUM_REQ-1:0]            wb_valid;
    logic [NUM_REQ-1:0]            wb_ready;
    logic [NUM_REQ*REG_ADDR_W-1:0] wb_rd;
    logic [NUM_REQ*XLEN-1:0]       wb_data;

    logic                          rf_reg_write;
    logic [REG_ADDR_W-1:0]         rf_write_add;
    logic [XLEN-1:0]               rf_write_data;
    logic [NUM_REGS-1:0]           busy_vec;
    logic                          err_stray_wb;

    modport master (
        output issue_valid, issue_rd, issue_rs1, issue_rs2,
        output wb_valid, wb_rd, wb_data,
        input  issue_stall, wb_ready,
        input  rf_reg_write, rf_write_add, rf_write_data, busy_vec, err_stray_wb
    );

    modport slave (
        input  issue_valid, issue_rd, issue_rs1, issue_rs2,
        input  wb_valid, wb_rd, wb_data,
        output issue_stall, wb_ready,
        output rf_reg_write, rf_write_add, rf_write_data, busy_vec, err_stray_wb
    );

endinterface

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// rtl/regfile_wb_scheduler_rr_arbiter.sv - round-robin arbiter; pointer names the highest-priority requester
module rr_arbiter #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] winner,
    output logic          valid
);
    import regfile_ctrl_pkg::*;

    logic [PW-1:0] ptr_q;
    logic [PW:0]   idx_w;
    logic [PW-1:0] idx;
    logic [PW:0]   next_w;
    logic [PW-1:0] ptr_next;

    // Search upward from the pointer, wrapping modulo N (N need not be a power of two).
    always_comb begin
        grant  = '0;
        winner = '0;
        valid  = 1'b0;
        idx_w  = '0;
        idx    = '0;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                idx_w = {1'b0, ptr_q} + (PW+1)'(k);
                if (idx_w >= (PW+1)'(N)) begin
                    idx_w = idx_w - (PW+1)'(N);
                end
                idx = idx_w[PW-1:0];
                if (!valid && req[idx]) begin
                    valid  = 1'b1;
                    winner = idx;
                end
            end
            if (valid) begin
                grant[winner] = 1'b1;
            end
        end
    end

    always_comb begin
        next_w = {1'b0, winner} + (PW+1)'(1);
        if (next_w >= (PW+1)'(N)) begin
            next_w = next_w - (PW+1)'(N);
        end
        ptr_next = next_w[PW-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else if (valid) begin
            ptr_q <= ptr_next;
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// rtl/regfile_wb_scheduler.sv - scoreboard hazard stall plus shared write port; REGFILE_WB_BYPASS_EN lets issue see same-cycle retirement
module regfile_wb_scheduler #(
    parameter int NUM_REQ    = 2,
    parameter int XLEN       = regfile_ctrl_pkg::XLEN,
    parameter int REG_ADDR_W = regfile_ctrl_pkg::REG_ADDR_W
) (
    input logic                   clk,
    input logic                   rst,
    regfile_wb_scheduler_if.slave bus
);
    import regfile_ctrl_pkg::*;

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]    grant;
    logic [PW-1:0]         winner;
    logic                  transfer;
    logic [REG_ADDR_W-1:0] sel_rd;
    logic [XLEN-1:0]       sel_data;

    logic [NUM_REGS-1:0]   busy_q;
    logic [NUM_REGS-1:0]   retire_vec;
    logic [NUM_REGS-1:0]   set_vec;
    logic [NUM_REGS-1:0]   hazard_busy;
    logic                  issue_stall;
    logic                  issue_accept;
    logic                  stray;

    logic                  rf_we_q;
    logic [REG_ADDR_W-1:0] rf_add_q;
    logic [XLEN-1:0]       rf_data_q;
    logic                  err_q;

    rr_arbiter #(.N(NUM_REQ), .PW(PW)) u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    (bus.wb_valid),
        .grant  (grant),
        .winner (winner),
        .valid  (transfer)
    );

    always_comb begin
        sel_rd   = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (winner == PW'(i)) begin
                sel_rd   = bus.wb_rd[i*REG_ADDR_W +: REG_ADDR_W];
                sel_data = bus.wb_data[i*XLEN +: XLEN];
            end
        end
    end

    // x0 never enters or leaves the scoreboard, so bit 0 stays clear.
    assign retire_vec = (transfer && sel_rd != '0) ? (NUM_REGS'(1) << sel_rd) : '0;

`ifdef REGFILE_WB_BYPASS_EN
    assign hazard_busy = busy_q & ~retire_vec;
`else
    assign hazard_busy = busy_q;
`endif

    assign issue_stall  = bus.issue_valid &
                          (hazard_busy[bus.issue_rs1] | hazard_busy[bus.issue_rs2] |
                           hazard_busy[bus.issue_rd]);
    assign issue_accept = bus.issue_valid & ~issue_stall;
    assign set_vec      = (issue_accept && bus.issue_rd != '0) ?
                          (NUM_REGS'(1) << bus.issue_rd) : '0;
    assign stray        = transfer && sel_rd != '0 && !busy_q[sel_rd];

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= '0;
            err_q     <= 1'b0;
            rf_we_q   <= 1'b0;
            rf_add_q  <= '0;
            rf_data_q <= '0;
        end else begin
            // Set after clear: a new producer keeps the register busy.
            busy_q <= (busy_q & ~retire_vec) | set_vec;
            if (stray) begin
                err_q <= 1'b1;
            end
            rf_we_q <= transfer && sel_rd != '0;
            if (transfer) begin
                rf_add_q  <= sel_rd;
                rf_data_q <= sel_data;
            end
        end
    end

    assign bus.wb_ready      = grant;
    assign bus.issue_stall   = issue_stall;
    assign bus.busy_vec      = busy_q;
    assign bus.err_stray_wb  = err_q;
    assign bus.rf_reg_write  = rf_we_q;
    assign bus.rf_write_add  = rf_add_q;
    assign bus.rf_write_data = rf_data_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// tb/tb_regfile_wb_scheduler.sv - directed and random checks of regfile_wb_scheduler against a scoreboard model
module tb_regfile_wb_scheduler;
    localparam int N  = 2;
    localparam int XW = 32;
    localparam int AW = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    regfile_wb_scheduler_if #(.NUM_REQ(N), .XLEN(XW), .REG_ADDR_W(AW)) bus ();

    regfile_wb_scheduler #(.NUM_REQ(N), .XLEN(XW), .REG_ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    bit [31:0] m_busy;
    int        m_ptr;
    bit        m_err;
    bit        m_we;
    bit [4:0]  m_add;
    bit [31:0] m_data;
    int        m_last_g;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit [4:0] req_rd(input int i);
        logic [N*AW-1:0] v;
        v = bus.wb_rd;
        return v[i*AW +: AW];
    endfunction

    function automatic bit [31:0] req_data(input int i);
        logic [N*XW-1:0] v;
        v = bus.wb_data;
        return v[i*XW +: XW];
    endfunction

    task automatic set_wb(input int i, input bit v, input bit [4:0] rd, input bit [31:0] d);
        bus.wb_valid[i]           = v;
        bus.wb_rd[i*AW +: AW]     = rd;
        bus.wb_data[i*XW +: XW]   = d;
    endtask

    task automatic set_issue(input bit v, input bit [4:0] rd, input bit [4:0] rs1, input bit [4:0] rs2);
        bus.issue_valid = v;
        bus.issue_rd    = rd;
        bus.issue_rs1   = rs1;
        bus.issue_rs2   = rs2;
    endtask

    // One clock: check combinational outputs mid-cycle, advance the model, check registered outputs.
    task automatic cycle();
        int        g;
        int        idx;
        bit [31:0] eff;
        bit        st;
        bit [N-1:0] gexp;
        bit [4:0]  grd;
        @(negedge clk);
        g = -1;
        if (!rst) begin
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (g < 0 && bus.wb_valid[idx]) g = idx;
            end
        end
        gexp = '0;
        if (g >= 0) gexp[g] = 1'b1;
        grd = (g >= 0) ? req_rd(g) : 5'd0;
        eff = m_busy;
`ifdef REGFILE_WB_BYPASS_EN
        if (g >= 0 && grd != 0) eff[grd] = 1'b0;
`endif
        st = bus.issue_valid && (eff[bus.issue_rs1] || eff[bus.issue_rs2] || eff[bus.issue_rd]);
        check("issue_stall", {31'd0, bus.issue_stall}, {31'd0, st});
        check("wb_ready", {{(32-N){1'b0}}, bus.wb_ready}, {{(32-N){1'b0}}, gexp});
        if (rst) begin
            m_busy = 0; m_ptr = 0; m_err = 0; m_we = 0; m_add = 0; m_data = 0;
        end else begin
            m_we = 0;
            if (g >= 0) begin
                m_we = (grd != 0);
                m_add = grd;
                m_data = req_data(g);
                if (grd != 0 && !m_busy[grd]) m_err = 1;
                if (grd != 0) m_busy[grd] = 1'b0;
                m_ptr = (g + 1) % N;
            end
            if (bus.issue_valid && !st && bus.issue_rd != 0) m_busy[bus.issue_rd] = 1'b1;
        end
        m_last_g = g;
        @(posedge clk);
        #1;
        check("busy_vec", bus.busy_vec, m_busy);
        check("rf_reg_write", {31'd0, bus.rf_reg_write}, {31'd0, m_we});
        check("rf_write_add", {27'd0, bus.rf_write_add}, {27'd0, m_add});
        check("rf_write_data", bus.rf_write_data, m_data);
        check("err_stray_wb", {31'd0, bus.err_stray_wb}, {31'd0, m_err});
    endtask

    task automatic idle_all();
        set_issue(0, 0, 0, 0);
        for (int i = 0; i < N; i++) set_wb(i, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
    endtask

    initial begin
        int live;
        bit [4:0] pick;
        rst = 1'b1;
        m_busy = 0; m_ptr = 0; m_err = 0; m_we = 0; m_add = 0; m_data = 0; m_last_g = -1;
        idle_all();
        cycle();
        cycle();
        rst = 1'b0;
        check("reset_busy", bus.busy_vec, 32'h0);
        check("reset_err", {31'd0, bus.err_stray_wb}, 32'h0);

        // RAW: issue x5, then a consumer of x5 waits for its writeback
        set_issue(1, 5, 1, 2);
        cycle();
        check("busy_x5", bus.busy_vec, 32'h20);
        set_issue(1, 10, 5, 0);
        cycle();
        cycle();
        set_wb(0, 1, 5, 32'hA5A5_0005);
        cycle();
        set_wb(0, 0, 0, 0);
        cycle();
        set_issue(0, 0, 0, 0);
        set_wb(1, 1, 10, 32'h0000_0010);
        cycle();
        set_wb(1, 0, 0, 0);
        cycle();
        check("raw_drained", bus.busy_vec, 32'h0);

        // Two continuous requesters from pointer 0 alternate
        do_reset();
        set_wb(0, 1, 3, 32'h3333_3333);
        set_wb(1, 1, 4, 32'h4444_4444);
        for (int c = 0; c < 4; c++) begin
            cycle();
            check("rr_add_seq", {27'd0, bus.rf_write_add}, (c % 2 == 0) ? 32'd3 : 32'd4);
        end
        idle_all();
        cycle();

        // Single writeback to x7
        do_reset();
        set_wb(0, 1, 7, 32'hDEAD_BEEF);
        cycle();
        check("wb7_we", {31'd0, bus.rf_reg_write}, 32'd1);
        check("wb7_data", bus.rf_write_data, 32'hDEAD_BEEF);
        set_wb(0, 0, 0, 0);
        cycle();
        check("wb7_we_drop", {31'd0, bus.rf_reg_write}, 32'd0);

        // x0 writeback is granted but never written
        do_reset();
        set_wb(1, 1, 0, 32'h0000_1234);
        cycle();
        check("x0_we", {31'd0, bus.rf_reg_write}, 32'd0);
        check("x0_err", {31'd0, bus.err_stray_wb}, 32'd0);
        set_wb(1, 0, 0, 0);

        // Stray writeback to x9 is sticky until reset
        set_wb(0, 1, 9, 32'h0909_0909);
        cycle();
        set_wb(0, 0, 0, 0);
        cycle();
        cycle();
        check("stray_sticky", {31'd0, bus.err_stray_wb}, 32'd1);
        do_reset();
        check("stray_reset", {31'd0, bus.err_stray_wb}, 32'd0);
        check("rf_data_reset", bus.rf_write_data, 32'd0);

        // WAW on x6, then reset releases the stall
        set_issue(1, 6, 0, 0);
        cycle();
        cycle();
        cycle();
        check("waw_busy", bus.busy_vec, 32'h40);
        do_reset();
        check("waw_reset", bus.busy_vec, 32'h0);
        cycle();

        // Random traffic respecting the hold-until-granted rule
        idle_all();
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            set_issue($urandom_range(0, 1), 5'($urandom_range(0, 7)),
                      5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            for (int i = 0; i < N; i++) begin
                if (!bus.wb_valid[i] || m_last_g == i) begin
                    if ($urandom_range(0, 1) == 1) begin
                        pick = 5'($urandom_range(0, 7));
                        live = 0;
                        for (int r = 1; r < 8; r++) if (m_busy[r]) live++;
                        if (live > 0 && $urandom_range(0, 3) != 0) begin
                            live = $urandom_range(1, live);
                            for (int r = 1; r < 8; r++) begin
                                if (m_busy[r]) begin
                                    live--;
                                    if (live == 0) pick = 5'(r);
                                end
                            end
                        end
                        set_wb(i, 1, pick, $urandom);
                    end else begin
                        set_wb(i, 0, 0, 0);
                    end
                end
            end
            cycle();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
